adc_scan_controller: RTL and testbench

- Sequences the AVR ADC through a software-selected set of channels by driving `channel` into avr_interface.
- Waits for each matching sample and stores the latest 10-bit result per channel in a 16-entry register file.
- Supports one-shot and continuous scans, with a per-channel timeout so a missing sample cannot stall the scan.
- Sits between avr_interface's ADC signals and user logic that reads channel results.

---
 rtl/adc_scan_controller.sv | 188 ++++++++++++++++++
 tb/tb_adc_scan_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_controller.sv
// adc_scan_controller
//   Walks the AVR ADC through a latched set of channels, one at a time in
//   ascending order. For each channel it waits for a sample with a matching
//   tag and stores it in a 16 x 10-bit result file. A per-channel timer skips
//   a channel that never answers. Scans can be one-shot or continuous.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   ready             avr_interface ready; low aborts to idle
//   enable[15:0]      channel mask, latched at scan start / restart
//   start             single-cycle scan request (ignored while busy)
//   continuous        restart automatically at end of scan
//   channel[3:0]      channel request to avr_interface
//   new_sample        sample strobe from avr_interface
//   sample[9:0]       sample value
//   sample_channel    channel tag of the sample
//   rd_ch[3:0]        result read address
//   rd_data[9:0]      stored result for rd_ch (combinational)
//   rd_valid          result_valid[rd_ch]
//   result_valid      per-channel valid bits
//   busy              scan in progress
//   scan_done         one-cycle pulse at end of a completed scan
//   timeout_err       one-cycle pulse when a channel times out
//   err_ch[3:0]       channel of the most recent timeout (held)
module adc_scan_controller #(
  parameter int          TIMEOUT_CYCLES   = 100000,
  parameter logic [3:0]  FIRST_CH_DEFAULT = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic [15:0] enable,
  input  logic        start,
  input  logic        continuous,
  output logic [3:0]  channel,
  input  logic        new_sample,
  input  logic [9:0]  sample,
  input  logic [3:0]  sample_channel,
  input  logic [3:0]  rd_ch,
  output logic [9:0]  rd_data,
  output logic        rd_valid,
  output logic [15:0] result_valid,
  output logic        busy,
  output logic        scan_done,
  output logic        timeout_err,
  output logic [3:0]  err_ch
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic [3:0]        ch_q, ch_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic [3:0]        errch_q, errch_d;
  logic [15:0]       rvalid_q, rvalid_d;
  logic [15:0][9:0]  res_q;
  logic              res_we;

  logic              accept, tmo;
  logic [3:0]        nxt_ch, en_lo;
  logic              nxt_found;

  // Next enabled channel strictly above the current one; never wraps, so a
  // scan ends at the highest set bit of the latched mask.
  always_comb begin
    nxt_ch    = ch_q;
    nxt_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch    = 4'(i);
        nxt_found = 1'b1;
      end
    end
  end

  // Lowest set bit of the live enable input, used when (re)latching.
  always_comb begin
    en_lo = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (enable[i]) en_lo = 4'(i);
    end
  end

  // Stale samples (wrong tag) are dropped and leave the timer running.
  assign accept = (state_q == WAIT) && new_sample && (sample_channel == ch_q);
  // Accept wins over a timeout landing in the same cycle.
  assign tmo    = (state_q == WAIT) && !accept && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    terr_d   = 1'b0;
    errch_d  = errch_q;
    rvalid_d = rvalid_q;
    res_we   = 1'b0;
    if (!ready) begin
      // Abort: results and valid bits survive, no status pulses.
      state_d = IDLE;
      ch_d    = FIRST_CH_DEFAULT;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_d = enable;
            if (|enable) begin
              state_d = WAIT;
              ch_d    = en_lo;
              timer_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        WAIT: begin
          timer_d = timer_q + 1'b1;
          if (accept || tmo) begin
            if (accept) begin
              res_we           = 1'b1;
              rvalid_d[ch_q]   = 1'b1;
            end else begin
              terr_d           = 1'b1;
              errch_d          = ch_q;
              rvalid_d[ch_q]   = 1'b0;
            end
            timer_d = '0;
            if (nxt_found) begin
              ch_d = nxt_ch;
            end else begin
              done_d = 1'b1;
              if (continuous) begin
                // Back-to-back restart with a fresh mask, no idle gap.
                mask_d = enable;
                if (|enable) ch_d = en_lo;
                else         state_d = IDLE;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ch_q     <= FIRST_CH_DEFAULT;
      timer_q  <= '0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      errch_q  <= '0;
      rvalid_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      errch_q  <= errch_d;
      rvalid_q <= rvalid_d;
      if (res_we) res_q[ch_q] <= sample;
    end
  end

  assign channel      = ch_q;
  assign busy         = (state_q == WAIT);
  assign scan_done    = done_q;
  assign timeout_err  = terr_q;
  assign err_ch       = errch_q;
  assign result_valid = rvalid_q;
  assign rd_data      = res_q[rd_ch];
  assign rd_valid     = rvalid_q[rd_ch];

endmodule

// File: tb/tb_adc_scan_controller.sv
// Bench for adc_scan_controller. Inputs are driven and outputs sampled on the
// falling clock edge. The reference is a transaction view: the expected
// channel order is the list of set mask bits, and results/valid bits live in
// plain arrays updated whenever the bench answers or withholds a sample.
module tb_adc_scan_controller;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready = 1'b1;
  logic [15:0] enable = '0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [3:0]  channel;
  logic        new_sample = 1'b0;
  logic [9:0]  sample = '0;
  logic [3:0]  sample_channel = '0;
  logic [3:0]  rd_ch = '0;
  logic [9:0]  rd_data;
  logic        rd_valid;
  logic [15:0] result_valid;
  logic        busy;
  logic        scan_done;
  logic        timeout_err;
  logic [3:0]  err_ch;

  int n_chk  = 0;
  int n_pass = 0;

  logic [9:0]  m_res [16];
  logic [15:0] m_val;

  adc_scan_controller #(.TIMEOUT_CYCLES(T), .FIRST_CH_DEFAULT(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .enable(enable), .start(start),
    .continuous(continuous), .channel(channel), .new_sample(new_sample),
    .sample(sample), .sample_channel(sample_channel), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid), .result_valid(result_valid),
    .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] rand_mask;
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel == 0) return 16'h0000;
    if (sel == 1) return 16'h8000 | 16'($urandom);
    return 16'($urandom);
  endfunction

  task automatic chk_reset;
    chk("rst_busy", busy, 0);
    chk("rst_channel", channel, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_err_ch", err_ch, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
  endtask

  task automatic chk_rd(input int ch);
    rd_ch = 4'(ch);
    #1;
    chk("rd_data", rd_data, m_res[ch]);
    chk("rd_valid", rd_valid, m_val[ch]);
  endtask

  task automatic drive_sample(input logic [3:0] tag, input logic [9:0] val);
    new_sample     = 1'b1;
    sample_channel = tag;
    sample         = val;
  endtask

  // Called on the first falling edge where channel ch is selected.
  task automatic serve(input int ch, input bit silent, input int delay, input bit stale,
                       input logic [3:0] stale_tag, input logic [9:0] val);
    chk("sel_channel", channel, ch);
    chk("sel_busy", busy, 1);
    if (silent) begin
      for (int k = 0; k < T - 1; k++) begin
        if (k == 1 && stale) drive_sample(stale_tag, 10'($urandom));
        step;
        new_sample = 1'b0;
        chk("no_early_tmo", timeout_err, 0);
      end
      step;
      m_val[ch] = 1'b0;
      chk("tmo_pulse", timeout_err, 1);
      chk("tmo_err_ch", err_ch, ch);
      chk("tmo_invalid", result_valid[ch], 0);
      chk_rd(ch);
    end else begin
      for (int k = 0; k < delay; k++) begin
        if (k == 0 && stale) drive_sample(stale_tag, 10'($urandom));
        step;
        new_sample = 1'b0;
        chk("wait_no_tmo", timeout_err, 0);
      end
      drive_sample(4'(ch), val);
      step;
      new_sample = 1'b0;
      m_res[ch]  = val;
      m_val[ch]  = 1'b1;
      chk("acc_no_tmo", timeout_err, 0);
      chk_rd(ch);
    end
  endtask

  task automatic start_scan(input logic [15:0] m);
    enable = m;
    start  = 1'b1;
    step;
    start = 1'b0;
    if (m != 0) begin
      chk("start_busy", busy, 1);
      chk("start_done", scan_done, 0);
    end else begin
      chk("zero_done", scan_done, 1);
      chk("zero_busy", busy, 0);
      step;
      chk("zero_done_pulse", scan_done, 0);
      chk("zero_busy2", busy, 0);
    end
  endtask

  // Serves every channel of mask in ascending order; enable is switched to
  // next_en right away so mid-scan changes must have no effect.
  task automatic scan_body(input logic [15:0] mask, input logic [15:0] next_en, input bit cont,
                           input bit directed, input logic [15:0] silent_mask);
    int q[$];
    int ch, dly;
    bit sil, stl;
    logic [3:0] tag;
    logic [9:0] val;
    for (int i = 0; i < 16; i++) if (mask[i]) q.push_back(i);
    enable     = next_en;
    continuous = cont;
    for (int idx = 0; idx < q.size(); idx++) begin
      ch = q[idx];
      if (directed) begin
        sil = silent_mask[ch];
        dly = 5;
        stl = 1'b1;
        tag = 4'(ch) ^ 4'd1;
        val = 10'h100 + 10'(ch);
      end else begin
        sil = ($urandom_range(0, 4) == 0);
        dly = ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, 6));
        stl = 1'($urandom_range(0, 1));
        tag = 4'(ch) ^ 4'($urandom_range(1, 15));
        val = 10'($urandom);
      end
      serve(ch, sil, dly, stl, tag, val);
      if (idx < q.size() - 1) begin
        chk("mid_done", scan_done, 0);
        chk("mid_busy", busy, 1);
      end else begin
        chk("end_done", scan_done, 1);
        chk("end_rvalid", result_valid, m_val);
        if (cont && next_en != 0) begin
          chk("cont_busy", busy, 1);
          chk("cont_channel", channel, lowest(next_en));
        end else begin
          chk("end_busy", busy, 0);
          if (!cont) chk("end_hold_ch", channel, ch);
          step;
          chk("done_pulse", scan_done, 0);
          chk("idle_busy", busy, 0);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] cur, nxt;
    bit running, c;
    for (int i = 0; i < 16; i++) m_res[i] = '0;
    m_val = '0;

    #1 rst_n = 1'b0;
    #2 chk_reset();
    step;
    rst_n = 1'b1;
    step;

    // Three-channel scan, each answered after 5 cycles
    start_scan(16'h0013);
    scan_body(16'h0013, 16'h0013, 1'b0, 1'b1, 16'h0000);
    chk_rd(4);
    chk("t1_rd4", rd_data, 10'h104);
    chk("t1_rvalid", result_valid, 16'h0013);

    // Stale ch3 sample before the ch2 answer
    start_scan(16'h0004);
    scan_body(16'h0004, 16'h0004, 1'b0, 1'b1, 16'h0000);
    chk("t2_rvalid3", result_valid[3], 0);
    chk("t2_rvalid2", result_valid[2], 1);

    // ch1 never answers
    start_scan(16'h0006);
    scan_body(16'h0006, 16'h0006, 1'b0, 1'b1, 16'h0002);
    chk("t3_rvalid1", result_valid[1], 0);

    // Continuous with a mask switch
    start_scan(16'h8001);
    scan_body(16'h8001, 16'h0002, 1'b1, 1'b1, 16'h0000);
    scan_body(16'h0002, 16'h0002, 1'b0, 1'b1, 16'h0000);

    // ready drop while waiting on ch4
    start_scan(16'h0011);
    serve(0, 1'b0, 2, 1'b0, 4'h1, 10'h3A5);
    chk("rd_ch4_sel", channel, 4);
    step;
    ready = 1'b0;
    step;
    chk("abort_busy", busy, 0);
    chk("abort_channel", channel, 0);
    chk("abort_done", scan_done, 0);
    ready = 1'b1;
    step;
    chk("abort_done2", scan_done, 0);
    chk("abort_terr", timeout_err, 0);
    chk("abort_rvalid", result_valid, m_val);
    chk("abort_keep0", result_valid[0], 1);

    // Randomized scans, one-shot and continuous
    running = 1'b0;
    cur = '0;
    for (int it = 0; it < 10; it++) begin
      if (!running) begin
        cur = rand_mask();
        start_scan(cur);
      end
      if (cur != 0) begin
        nxt = rand_mask();
        c   = 1'($urandom_range(0, 1));
        scan_body(cur, nxt, c, 1'b0, 16'h0000);
        running = c && (nxt != 0);
        cur = nxt;
      end
    end
    if (running) scan_body(cur, cur, 1'b0, 1'b0, 16'h0000);

    // Empty mask
    start_scan(16'h0000);

    // Asynchronous reset in the middle of a scan
    start_scan(16'h00F0);
    step;
    step;
    rd_ch = 4'd2;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    for (int i = 0; i < 16; i++) m_res[i] = '0;
    m_val = '0;
    enable = '0;
    continuous = 1'b0;
    step;
    rst_n = 1'b1;
    step;

    // Fresh scan after reset
    start_scan(16'h0020);
    scan_body(16'h0020, 16'h0020, 1'b0, 1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
